// File: rtl/mos6502s_stack_engine_pkg.sv
// mos6502s stack engine shared types and defaults.
// Imported by the stack engine and its sp register.
package mos6502s_pkg;

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    DONE
  } stack_state_t;

  localparam logic OP_PUSH = 1'b0;
  localparam logic OP_PULL = 1'b1;

  localparam int unsigned DEF_STACK_PAGE = 1;
  localparam int unsigned DEF_RESET_SP   = 'hFD;

  function automatic logic [7:0] byte_sel(
    input logic [23:0] d,
    input logic [1:0]  i
  );
    logic [7:0] b;
    b = '0;
    unique case (i)
      2'd0:    b = d[7:0];
      2'd1:    b = d[15:8];
      2'd2:    b = d[23:16];
      default: b = '0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/mos6502s_stack_engine_if.sv
// Memory-side req/ack bus of the stack engine.
// master = engine, slave = memory arbiter.
interface mos6502s_stack_engine_if #(
  parameter int ADDR_WIDTH = 16
);
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [7:0]            mem_wdata;
  logic                  mem_ack;
  logic [7:0]            mem_rdata;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_ack,
    output mem_rdata
  );
endinterface

// File: rtl/mos6502s_stack_engine_sp_reg.sv
// Stack pointer register: load/dec/inc mux, sticky wrap flag
// and page-prefixed stack addresses.
module mos6502s_sp_reg
  import mos6502s_pkg::*;
#(
  parameter int          SP_WIDTH   = 8,
  parameter int          ADDR_WIDTH = 16,
  parameter int unsigned STACK_PAGE = DEF_STACK_PAGE,
  parameter int unsigned RESET_SP   = DEF_RESET_SP
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [SP_WIDTH-1:0]   data_in,
  input  logic                  inc,
  input  logic                  dec,
  output logic [SP_WIDTH-1:0]   sp,
  output logic                  wrap,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [ADDR_WIDTH-1:0] addr_plus1
);
  localparam int PW = ADDR_WIDTH - SP_WIDTH;
  localparam logic [PW-1:0] PAGE = PW'(STACK_PAGE);
  localparam logic [SP_WIDTH-1:0] SP_RST = SP_WIDTH'(RESET_SP);
  localparam logic [SP_WIDTH-1:0] ONE = SP_WIDTH'(1);

  logic [SP_WIDTH-1:0] sp_q, sp_d;
  logic                wrap_q, wrap_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp_q   <= SP_RST;
      wrap_q <= 1'b0;
    end else begin
      sp_q   <= sp_d;
      wrap_q <= wrap_d;
    end
  end

  // load beats dec beats inc; a load also clears wrap
  always_comb begin
    sp_d   = sp_q;
    wrap_d = wrap_q;
    priority case (1'b1)
      load: begin
        sp_d   = data_in;
        wrap_d = 1'b0;
      end
      dec: begin
        sp_d = sp_q - ONE;
        if (sp_q == '0) wrap_d = 1'b1;
      end
      inc: begin
        sp_d = sp_q + ONE;
        if (&sp_q) wrap_d = 1'b1;
      end
      default: ;
    endcase
  end

  assign sp         = sp_q;
  assign wrap       = wrap_q;
  assign addr       = {PAGE, sp_q};
  assign addr_plus1 = {PAGE, sp_q + ONE};

endmodule

// File: rtl/mos6502s_stack_engine.sv
// Stack engine: sequences 0-3 byte pushes/pulls over the
// req/ack bus and owns the stack pointer.
module mos6502s_stack_engine
  import mos6502s_pkg::*;
#(
  parameter int          SP_WIDTH   = 8,
  parameter int          ADDR_WIDTH = 16,
  parameter int unsigned STACK_PAGE = DEF_STACK_PAGE,
  parameter int unsigned RESET_SP   = DEF_RESET_SP
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [SP_WIDTH-1:0]   data_in,
  input  logic                  inc,
  input  logic                  dec,
  input  logic                  start,
  input  logic                  op,
  input  logic [1:0]            count,
  input  logic [23:0]           push_data,
  mos6502s_stack_engine_if.master mem,
  output logic [23:0]           pull_data,
  output logic                  busy,
  output logic                  done,
  output logic [SP_WIDTH-1:0]   sp,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [ADDR_WIDTH-1:0] addr_plus1,
  output logic                  wrap
);
  stack_state_t state_q, state_d;
  logic         op_q;
  logic [1:0]   cnt_q, rem_q;
  logic [23:0]  pd_q, pull_q, pull_nx;
  logic [1:0]   pull_idx;
  logic         idle, req, ack, is_push;
  logic         sp_load, sp_inc, sp_dec;

  assign idle    = (state_q == IDLE);
  assign req     = (state_q == XFER);
  assign ack     = req && mem.mem_ack;
  assign is_push = (op_q == OP_PUSH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= OP_PUSH;
      cnt_q   <= '0;
      rem_q   <= '0;
      pd_q    <= '0;
      pull_q  <= '0;
    end else begin
      state_q <= state_d;
      if (idle && start) begin
        op_q   <= op;
        cnt_q  <= count;
        rem_q  <= count;
        pd_q   <= push_data;
        pull_q <= '0;
      end else if (ack) begin
        rem_q <= rem_q - 2'd1;
        if (!is_push) pull_q <= pull_nx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = (count == 2'd0) ? DONE : XFER;
      end
      XFER: begin
        if (mem.mem_ack && rem_q == 2'd1) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // pulls fill pull_data from byte 0 upwards
  assign pull_idx = cnt_q - rem_q;

  always_comb begin
    pull_nx = pull_q;
    unique case (pull_idx)
      2'd0:    pull_nx[7:0]   = mem.mem_rdata;
      2'd1:    pull_nx[15:8]  = mem.mem_rdata;
      2'd2:    pull_nx[23:16] = mem.mem_rdata;
      default: ;
    endcase
  end

  assign sp_load = idle && load;
  assign sp_dec  = (idle && dec) || (ack && is_push);
  assign sp_inc  = (idle && inc) || (ack && !is_push);

  mos6502s_sp_reg #(
    .SP_WIDTH   (SP_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .STACK_PAGE (STACK_PAGE),
    .RESET_SP   (RESET_SP)
  ) u_sp (
    .clk        (clk),
    .rst        (rst),
    .load       (sp_load),
    .data_in    (data_in),
    .inc        (sp_inc),
    .dec        (sp_dec),
    .sp         (sp),
    .wrap       (wrap),
    .addr       (addr),
    .addr_plus1 (addr_plus1)
  );

  // bus fields only change on ack, so they hold across wait states
  assign mem.mem_req   = req;
  assign mem.mem_we    = req && is_push;
  assign mem.mem_addr  = !req ? '0 :
                         is_push ? addr : addr_plus1;
  assign mem.mem_wdata = (req && is_push) ?
                         byte_sel(pd_q, rem_q - 2'd1) : 8'h00;

  assign pull_data = pull_q;
  assign busy      = req;
  assign done      = (state_q == DONE);

endmodule

// File: doc/mos6502s_stack_engine.md
# mos6502s_stack_engine

Parametrised stack unit for the mos6502s core: holds the stack pointer and autonomously sequences 1–3 byte pushes and pulls (JSR/RTS/BRK/RTI/PHA/PLA) over a req/ack memory handshake, so the core issues one start instead of stepping the pointer per byte. Sits between the control unit and the memory arbiter; stack addresses are {STACK_PAGE, sp} with modulo pointer arithmetic.

## Interface
- SP_WIDTH, 8: stack pointer width.
- ADDR_WIDTH, 16: memory address width; page field is ADDR_WIDTH-SP_WIDTH bits.
- STACK_PAGE, 1: page prepended to sp.
- RESET_SP, 8'hFD: sp value after reset.
- clk  in  1  clock; everything on rising edge.
- rst  in  1  asynchronous, active-high reset.
- load  in  1  idle only: sp <= data_in.
- data_in  in  SP_WIDTH  load value.
- inc / dec  in  1  idle only: single-step sp.
- start  in  1  begin a transfer; sampled only in IDLE.
- op  in  1  0 = push, 1 = pull.
- count  in  2  bytes to transfer, 0–3.
- push_data  in  24  byte i at [8i+7:8i]; captured at start.
- mem_req  out  1  bus request.
- mem_we  out  1  1 for push writes.
- mem_addr  out  ADDR_WIDTH  bus address.
- mem_wdata  out  8  write byte.
- mem_ack  in  1  completes current byte in the cycle it is high with mem_req.
- mem_rdata  in  8  read byte, valid with mem_ack.
- pull_data  out  24  assembled pull result, byte i at [8i+7:8i].
- busy  out  1  high in XFER.
- done  out  1  one-cycle pulse at transfer end.
- sp  out  SP_WIDTH  current pointer.
- addr / addr_plus1  out  ADDR_WIDTH  {STACK_PAGE, sp} and {STACK_PAGE, sp+1 mod 2^SP_WIDTH}.
- wrap  out  1  sticky pointer-wrap flag.

## Operation
- States: IDLE, XFER, DONE.
  - IDLE + start: capture op, count, push_data; set remaining = count. Go to XFER, or to DONE directly if count = 0 (no bus cycle).
  - XFER: on each acked byte, decrement remaining; after the last ack, go to DONE.
  - DONE: lasts one cycle, then returns to IDLE. start is ignored in DONE.
- Push, byte k = remaining-1 (highest byte first):
  - mem_addr = {STACK_PAGE, sp}, mem_we = 1, mem_wdata = push_data byte k.
  - On ack: sp <= sp-1.
- Pull, byte j = count-remaining (byte 0 first):
  - mem_addr = {STACK_PAGE, sp+1}, mem_we = 0.
  - On ack: pull_data byte j <= mem_rdata and sp <= sp+1.
- Bytes of pull_data not written by the current pull read 0; pull_data is cleared at start.
- A push of N bytes followed by a pull of N bytes returns identical data and an identical sp.
- Idle pointer ops, priority load > dec > inc. inc, dec and load are ignored outside IDLE.
- Arithmetic is modulo 2^SP_WIDTH.
  - wrap sets on any decrement from 0 or increment from all-ones, whether sequenced or direct.
  - wrap clears only on load or rst.
  - If load and a wrapping dec are asserted together, load wins and wrap clears.
- mem_addr, mem_we and mem_wdata must hold stable while mem_req is high and mem_ack is low.

## Timing
- Reset values, applied immediately:
  - state IDLE; sp = RESET_SP; wrap = 0; pull_data = 0.
  - mem_req, mem_we, busy, done = 0; mem_addr and mem_wdata = 0.
- Reset mid-transfer drops mem_req in the same cycle and abandons the transfer, with no done.
- start sampled at edge 0: mem_req high from cycle 1.
- With mem_ack tied high, an N-byte transfer:
  - occupies cycles 1..N;
  - done is high in cycle N+1, with sp and pull_data final in that cycle.
  - count = 0: done in cycle 1.
- Wait states stretch the current byte; a zero-wait ack (ack in the first req cycle) is legal.
- busy and done are never high together.
- mem_req is driven from state registers and is not combinational on mem_ack.

## Structure
- Package mos6502s_pkg holds:
  - state enum stack_state_t {IDLE, XFER, DONE};
  - constants OP_PUSH = 0, OP_PULL = 1;
  - default STACK_PAGE and RESET_SP.
- Sub-module mos6502s_sp_reg: the sp register, the ±1/load next-value mux, wrap detection and addr/addr_plus1 generation, parametrised by SP_WIDTH/ADDR_WIDTH/STACK_PAGE/RESET_SP.
- The engine keeps the FSM, remaining counter, captured operands and pull_data assembly.

## Test plan
- Reset: assert rst mid-push at cycle 2 of 3 -> mem_req falls in the same cycle; sp=8'hFD, wrap=0, no done.
- Push 3, ack tied high:
  - Stimulus: push_data=24'hA1B2C3, sp=FD.
  - Writes: C3 is not first. Order is A1@01FD, B2@01FC, C3@01FB.
  - done in cycle 4; sp=FA.
- Pull 3 with 2 wait states per byte, from sp=FA:
  - Reads at 01FB, 01FC, 01FD return C3, B2, A1.
  - pull_data=24'hA1B2C3; sp=FD; done in cycle 10.
- Wrap on push: load 8'h00, push 2 (data 24'h00_5566).
  - Writes 55@0100, 66@01FF.
  - sp=FE, wrap=1.
  - A following load 8'h10 clears wrap.
- Idle priority and lock-out:
  - load=1, dec=1, data_in=8'h40 -> sp=40.
  - inc during XFER -> ignored.
  - start with count=0 -> no mem_req, done the next cycle.
- Parametrised build (SP_WIDTH=10, ADDR_WIDTH=16, STACK_PAGE=6'h3):
  - pull 1 from sp=10'h3FF -> reads address 16'h0C00, sp=000, wrap=1.
